// File: rtl/handshake_pkg.sv
// handshake_pkg
//   Shared declarations for the handshake constant-sequence generator.
//   - occ_e    : occupancy of the 2-entry elastic buffer (EMPTY, ONE, FULL)
//   - width_of : counter width for a given range, never less than 1 bit
package handshake_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_e;

  // ceil(log2(n)) with a 1-bit floor, so a range of 1 still gets a counter.
  function automatic int unsigned width_of(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/handshake_elastic_buffer_2.sv
// handshake_elastic_buffer_2
//   Two-entry elastic buffer with fully registered handshake outputs.
//   The head register drives the consumer directly; the tail register
//   catches the one extra token that can arrive while the head is stalled.
// Ports
//   clk          : rising-edge clock
//   rst          : synchronous reset, active low
//   i_push_valid : producer offers i_push_data
//   o_push_ready : registered; high whenever the buffer is not FULL
//   i_push_data  : payload in (WIDTH bits)
//   o_pop_valid  : registered; head holds a token
//   i_pop_ready  : consumer takes the head token
//   o_pop_data   : registered head payload
module handshake_elastic_buffer_2
  import handshake_pkg::*;
#(
  parameter int unsigned WIDTH = 33
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push_valid,
  output logic             o_push_ready,
  input  logic [WIDTH-1:0] i_push_data,
  output logic             o_pop_valid,
  input  logic             i_pop_ready,
  output logic [WIDTH-1:0] o_pop_data
);

  occ_e             r_occ;
  logic             r_valid;
  logic             r_ready;
  logic [WIDTH-1:0] r_head;
  logic [WIDTH-1:0] r_tail;

  logic w_push;
  logic w_pop;

  assign w_push = i_push_valid & r_ready;
  assign w_pop  = r_valid & i_pop_ready;

  // r_ready is computed from the next occupancy, so it only ever depends on
  // registered state and never combinationally on i_pop_ready.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_occ   <= EMPTY;
      r_valid <= 1'b0;
      r_ready <= 1'b0;
      r_head  <= '0;
      r_tail  <= '0;
    end else begin
      case (r_occ)
        EMPTY: begin
          r_ready <= 1'b1;
          if (w_push) begin
            r_head  <= i_push_data;
            r_valid <= 1'b1;
            r_occ   <= ONE;
          end
        end
        ONE: begin
          case ({w_push, w_pop})
            2'b10: begin
              r_tail  <= i_push_data;
              r_occ   <= FULL;
              r_ready <= 1'b0;
            end
            2'b01: begin
              r_valid <= 1'b0;
              r_occ   <= EMPTY;
              r_ready <= 1'b1;
            end
            2'b11: begin
              // Head leaves and the new token replaces it in the same cycle.
              r_head  <= i_push_data;
              r_ready <= 1'b1;
            end
            default: r_ready <= 1'b1;
          endcase
        end
        FULL: begin
          // No push can happen here: r_ready is low throughout FULL.
          if (w_pop) begin
            r_head  <= r_tail;
            r_occ   <= ONE;
            r_ready <= 1'b1;
          end else begin
            r_ready <= 1'b0;
          end
        end
        default: begin
          r_occ   <= EMPTY;
          r_valid <= 1'b0;
          r_ready <= 1'b0;
        end
      endcase
    end
  end

  assign o_push_ready = r_ready;
  assign o_pop_valid  = r_valid;
  assign o_pop_data   = r_head;

endmodule

// File: rtl/handshake_constant_seq.sv
// handshake_constant_seq
//   Emits one value per accepted trigger token: BASE_VALUE + idx*STRIDE,
//   with idx cycling 0..SEQ_LEN-1. The value is kept in an accumulator so
//   no multiplier is needed. Tokens pass through a 2-entry elastic buffer,
//   giving one cycle of latency and full throughput.
// Ports
//   clk        : rising-edge clock
//   rst        : synchronous reset, active low
//   ctrl_valid : trigger token offered
//   ctrl_ready : registered; trigger can be accepted
//   outs       : emitted value (DATA_WIDTH bits)
//   outs_valid : outs holds a token
//   outs_last  : token is sequence element SEQ_LEN-1
//   outs_ready : consumer accepts the token
module handshake_constant_seq
  import handshake_pkg::*;
#(
  parameter int unsigned          DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] BASE_VALUE = '0,
  parameter logic [DATA_WIDTH-1:0] STRIDE     = '0,
  parameter int unsigned          SEQ_LEN    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ctrl_valid,
  output logic                  ctrl_ready,
  output logic [DATA_WIDTH-1:0] outs,
  output logic                  outs_valid,
  output logic                  outs_last,
  input  logic                  outs_ready
);

  localparam int unsigned      IDX_W    = width_of(SEQ_LEN);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SEQ_LEN - 1);

  logic [IDX_W-1:0]      r_idx;
  logic [DATA_WIDTH-1:0] r_acc;

  logic                  w_accept;
  logic                  w_last;
  logic [DATA_WIDTH:0]   w_buf_in;
  logic [DATA_WIDTH:0]   w_buf_out;

  assign w_accept = ctrl_valid & ctrl_ready;
  assign w_last   = (r_idx == LAST_IDX);
  assign w_buf_in = {w_last, r_acc};

  // The accumulator always holds the value of the token that the next
  // acceptance will emit; on the last element it reloads the base.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_idx <= '0;
      r_acc <= BASE_VALUE;
    end else if (w_accept) begin
      if (w_last) begin
        r_idx <= '0;
        r_acc <= BASE_VALUE;
      end else begin
        r_idx <= r_idx + IDX_W'(1);
        r_acc <= r_acc + STRIDE;
      end
    end
  end

  handshake_elastic_buffer_2 #(
    .WIDTH(DATA_WIDTH + 1)
  ) u_buf (
    .clk         (clk),
    .rst         (rst),
    .i_push_valid(ctrl_valid),
    .o_push_ready(ctrl_ready),
    .i_push_data (w_buf_in),
    .o_pop_valid (outs_valid),
    .i_pop_ready (outs_ready),
    .o_pop_data  (w_buf_out)
  );

  assign outs      = w_buf_out[DATA_WIDTH-1:0];
  assign outs_last = w_buf_out[DATA_WIDTH];

endmodule

// File: tb/tb_handshake_constant_seq.sv
// tb_handshake_constant_seq
//   Directed bench for handshake_constant_seq. Three instances share clk/rst:
//   A: base F0B, stride 1, length 4; B: stride 0F8, length 3; C: length 1.
//   Inputs change and outputs are sampled on the falling edge.
module tb_handshake_constant_seq;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic        a_ctrl_valid = 1'b0, a_outs_ready = 1'b0;
  logic        a_ctrl_ready, a_outs_valid, a_outs_last;
  logic [11:0] a_outs;
  logic        b_ctrl_valid = 1'b0, b_outs_ready = 1'b0;
  logic        b_ctrl_ready, b_outs_valid, b_outs_last;
  logic [11:0] b_outs;
  logic        c_ctrl_valid = 1'b0, c_outs_ready = 1'b0;
  logic        c_ctrl_ready, c_outs_valid, c_outs_last;
  logic [11:0] c_outs;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  handshake_constant_seq #(
    .DATA_WIDTH(12), .BASE_VALUE(12'hF0B), .STRIDE(12'h001), .SEQ_LEN(4)
  ) dut_a (
    .clk(clk), .rst(rst), .ctrl_valid(a_ctrl_valid), .ctrl_ready(a_ctrl_ready),
    .outs(a_outs), .outs_valid(a_outs_valid), .outs_last(a_outs_last),
    .outs_ready(a_outs_ready)
  );

  handshake_constant_seq #(
    .DATA_WIDTH(12), .BASE_VALUE(12'hF0B), .STRIDE(12'h0F8), .SEQ_LEN(3)
  ) dut_b (
    .clk(clk), .rst(rst), .ctrl_valid(b_ctrl_valid), .ctrl_ready(b_ctrl_ready),
    .outs(b_outs), .outs_valid(b_outs_valid), .outs_last(b_outs_last),
    .outs_ready(b_outs_ready)
  );

  handshake_constant_seq #(
    .DATA_WIDTH(12), .BASE_VALUE(12'hF0B), .STRIDE(12'h001), .SEQ_LEN(1)
  ) dut_c (
    .clk(clk), .rst(rst), .ctrl_valid(c_ctrl_valid), .ctrl_ready(c_ctrl_ready),
    .outs(c_outs), .outs_valid(c_outs_valid), .outs_last(c_outs_last),
    .outs_ready(c_outs_ready)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    a_ctrl_valid = 0; a_outs_ready = 0;
    b_ctrl_valid = 0; b_outs_ready = 0;
    c_ctrl_valid = 0; c_outs_ready = 0;
    rst = 0;
    tick();
    rst = 1;
    tick();
  endtask

  task automatic test_reset();
    rst = 0;
    tick();
    tick();
    total_cnt++;
    if (a_outs_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", a_outs_valid);
    else pass_cnt++;
    total_cnt++;
    if (a_ctrl_ready !== 1'b0) $display("FAIL reset_ctrl_ready: got %b want 0", a_ctrl_ready);
    else pass_cnt++;
    total_cnt++;
    if (a_outs !== 12'h000) $display("FAIL reset_outs: got %h want 000", a_outs);
    else pass_cnt++;
    total_cnt++;
    if (c_outs_last !== 1'b0) $display("FAIL reset_last: got %b want 0", c_outs_last);
    else pass_cnt++;
    rst = 1;
    tick();
    total_cnt++;
    if (a_ctrl_ready !== 1'b1) $display("FAIL release_ctrl_ready: got %b want 1", a_ctrl_ready);
    else pass_cnt++;
    total_cnt++;
    if (a_outs_valid !== 1'b0) $display("FAIL release_valid: got %b want 0", a_outs_valid);
    else pass_cnt++;
  endtask

  task automatic test_streaming();
    logic [11:0] exp_v [6] = '{12'hF0B, 12'hF0C, 12'hF0D, 12'hF0E, 12'hF0B, 12'hF0C};
    logic        exp_l [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    do_reset();
    a_outs_ready = 1; a_ctrl_valid = 1;
    for (int i = 0; i < 6; i++) begin
      tick();
      $display("stream tok %0d: outs=%h last=%b valid=%b", i, a_outs, a_outs_last, a_outs_valid);
      total_cnt++;
      if (a_outs_valid !== 1'b1 || a_outs !== exp_v[i])
        $display("FAIL stream_val[%0d]: got v=%b %h want v=1 %h", i, a_outs_valid, a_outs, exp_v[i]);
      else pass_cnt++;
      total_cnt++;
      if (a_outs_last !== exp_l[i])
        $display("FAIL stream_last[%0d]: got %b want %b", i, a_outs_last, exp_l[i]);
      else pass_cnt++;
      total_cnt++;
      if (a_ctrl_ready !== 1'b1)
        $display("FAIL stream_ready[%0d]: got %b want 1", i, a_ctrl_ready);
      else pass_cnt++;
    end
    a_ctrl_valid = 0;
    tick();
    total_cnt++;
    if (a_outs_valid !== 1'b0) $display("FAIL stream_drain: got %b want 0", a_outs_valid);
    else pass_cnt++;
  endtask

  task automatic test_backpressure();
    do_reset();
    a_outs_ready = 0; a_ctrl_valid = 1;
    tick();
    total_cnt++;
    if (a_ctrl_ready !== 1'b1 || a_outs !== 12'hF0B)
      $display("FAIL bp_first: got rdy=%b outs=%h want rdy=1 outs=F0B", a_ctrl_ready, a_outs);
    else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      tick();
      $display("bp hold %0d: outs=%h valid=%b ctrl_ready=%b", i, a_outs, a_outs_valid, a_ctrl_ready);
      total_cnt++;
      if (a_ctrl_ready !== 1'b0)
        $display("FAIL bp_ready[%0d]: got %b want 0", i, a_ctrl_ready);
      else pass_cnt++;
      total_cnt++;
      if (a_outs_valid !== 1'b1 || a_outs !== 12'hF0B || a_outs_last !== 1'b0)
        $display("FAIL bp_hold[%0d]: got v=%b %h l=%b want v=1 F0B l=0", i, a_outs_valid, a_outs, a_outs_last);
      else pass_cnt++;
    end
    a_ctrl_valid = 0; a_outs_ready = 1;
    tick();
    total_cnt++;
    if (a_outs_valid !== 1'b1 || a_outs !== 12'hF0C || a_ctrl_ready !== 1'b1)
      $display("FAIL bp_drain1: got v=%b %h rdy=%b want v=1 F0C rdy=1", a_outs_valid, a_outs, a_ctrl_ready);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (a_outs_valid !== 1'b0) $display("FAIL bp_drain2: got v=%b want 0", a_outs_valid);
    else pass_cnt++;
    // Stalled offers must not have advanced the sequence: next is F0D.
    a_ctrl_valid = 1;
    tick();
    a_ctrl_valid = 0;
    total_cnt++;
    if (a_outs_valid !== 1'b1 || a_outs !== 12'hF0D)
      $display("FAIL bp_no_skip: got v=%b %h want v=1 F0D", a_outs_valid, a_outs);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_push_pop_one();
    logic [11:0] exp_v [3] = '{12'hF0C, 12'hF0D, 12'hF0E};
    do_reset();
    a_outs_ready = 0; a_ctrl_valid = 1;
    tick();
    a_outs_ready = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      $display("pushpop tok %0d: outs=%h last=%b", i, a_outs, a_outs_last);
      total_cnt++;
      if (a_outs_valid !== 1'b1 || a_outs !== exp_v[i] || a_ctrl_ready !== 1'b1)
        $display("FAIL pushpop[%0d]: got v=%b %h rdy=%b want v=1 %h rdy=1",
                 i, a_outs_valid, a_outs, a_ctrl_ready, exp_v[i]);
      else pass_cnt++;
    end
    total_cnt++;
    if (a_outs_last !== 1'b1) $display("FAIL pushpop_last: got %b want 1", a_outs_last);
    else pass_cnt++;
    a_ctrl_valid = 0;
    tick();
    // Occupancy was ONE: a single pop empties it.
    total_cnt++;
    if (a_outs_valid !== 1'b0) $display("FAIL pushpop_empty: got %b want 0", a_outs_valid);
    else pass_cnt++;
  endtask

  task automatic test_wrap();
    logic [11:0] exp_v [4] = '{12'hF0B, 12'h003, 12'h0FB, 12'hF0B};
    logic        exp_l [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    do_reset();
    b_outs_ready = 1; b_ctrl_valid = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      $display("wrap tok %0d: outs=%h last=%b", i, b_outs, b_outs_last);
      total_cnt++;
      if (b_outs_valid !== 1'b1 || b_outs !== exp_v[i] || b_outs_last !== exp_l[i])
        $display("FAIL wrap[%0d]: got v=%b %h l=%b want v=1 %h l=%b",
                 i, b_outs_valid, b_outs, b_outs_last, exp_v[i], exp_l[i]);
      else pass_cnt++;
    end
    b_ctrl_valid = 0;
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    a_outs_ready = 0; a_ctrl_valid = 1;
    tick();
    tick();
    rst = 0;
    tick();
    total_cnt++;
    if (a_outs_valid !== 1'b0 || a_ctrl_ready !== 1'b0)
      $display("FAIL midrst_during: got v=%b rdy=%b want 0 0", a_outs_valid, a_ctrl_ready);
    else pass_cnt++;
    rst = 1; a_outs_ready = 1;
    tick();
    total_cnt++;
    if (a_outs_valid !== 1'b0 || a_ctrl_ready !== 1'b1)
      $display("FAIL midrst_release: got v=%b rdy=%b want 0 1", a_outs_valid, a_ctrl_ready);
    else pass_cnt++;
    tick();
    $display("midrst tok: outs=%h valid=%b", a_outs, a_outs_valid);
    total_cnt++;
    if (a_outs_valid !== 1'b1 || a_outs !== 12'hF0B)
      $display("FAIL midrst_first: got v=%b %h want v=1 F0B", a_outs_valid, a_outs);
    else pass_cnt++;
    a_ctrl_valid = 0;
    tick();
  endtask

  task automatic test_seq_len1();
    do_reset();
    c_outs_ready = 1; c_ctrl_valid = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      $display("len1 tok %0d: outs=%h last=%b", i, c_outs, c_outs_last);
      total_cnt++;
      if (c_outs_valid !== 1'b1 || c_outs !== 12'hF0B || c_outs_last !== 1'b1)
        $display("FAIL len1[%0d]: got v=%b %h l=%b want v=1 F0B l=1",
                 i, c_outs_valid, c_outs, c_outs_last);
      else pass_cnt++;
    end
    c_ctrl_valid = 0;
    tick();
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_push_pop_one();
    test_wrap();
    test_reset_mid();
    test_seq_len1();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/handshake_constant_seq.md
HANDSHAKE_CONSTANT_SEQ -- requirements
Module: handshake_constant_seq

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: width of outs.
REQ-002 SHALL have parameter BASE_VALUE, default 0: first emitted value (DATA_WIDTH bits).
REQ-003 SHALL have parameter STRIDE, default 0: increment added per emitted token, taken modulo 2^DATA_WIDTH.
REQ-004 SHALL have parameter SEQ_LEN, default 1: sequence length before wrap; legal range 1..65535, where 1 gives a pure constant.
REQ-005 SHALL have one clock and a synchronous, active-low reset: clk and rst.
REQ-006 SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-007 SHALL have port rst, input, 1 bit: synchronous reset, asserted low.
REQ-008 SHALL have port ctrl_valid, input, 1 bit: a trigger token is offered.
REQ-009 SHALL have port ctrl_ready, output, 1 bit: the block accepts a trigger token.
REQ-010 SHALL have port outs, output, DATA_WIDTH bits: the emitted value.
REQ-011 SHALL have port outs_valid, output, 1 bit: outs holds a valid token.
REQ-012 SHALL have port outs_last, output, 1 bit: the current token is the final element of the sequence (index SEQ_LEN-1).
REQ-013 SHALL have port outs_ready, input, 1 bit: the consumer accepts a token.

Function
REQ-014 SHALL accept a ctrl token on any cycle where ctrl_valid and ctrl_ready are both high at the rising edge of clk.
REQ-015 SHALL generate, for each accepted ctrl token, one output token with value BASE_VALUE + idx*STRIDE (mod 2^DATA_WIDTH), where idx is the running sequence index.
REQ-016 SHALL hold idx in a counter of ceil(log2(SEQ_LEN)) bits, minimum 1 bit, reset to 0.
REQ-017 SHALL increment idx on each accepted ctrl token and wrap it to 0 after SEQ_LEN-1.
REQ-018 SHALL keep the current value in an accumulator register (no multiplier): add STRIDE on each acceptance, and reload BASE_VALUE on wrap.
REQ-019 SHALL buffer output tokens in a 2-entry elastic buffer with occupancy states EMPTY, ONE and FULL.
REQ-020 SHALL implement these occupancy transitions:
  - push only: EMPTY->ONE, ONE->FULL.
  - pop only: FULL->ONE, ONE->EMPTY.
  - push and pop together: occupancy unchanged.
REQ-021 SHALL have a latency of exactly one cycle: a token accepted at edge N is presented on outs/outs_valid after edge N.
REQ-022 SHALL drive ctrl_ready from a register: high when occupancy is not FULL, with no combinational path from outs_ready to ctrl_ready.
REQ-023 SHALL pop a token when outs_valid and outs_ready are both high at the edge.
REQ-024 SHALL keep outs, outs_last and outs_valid stable while outs_valid is high and outs_ready is low.
REQ-025 SHALL deliver tokens strictly in acceptance order with no loss or duplication under any valid/ready pattern.
REQ-026 SHALL accept a push in the ONE state while a pop occurs in the same cycle, without a bubble.
REQ-027 SHALL sustain throughput of 1 token/cycle when outs_ready is held high.
REQ-028 SHALL leave idx and the accumulator unchanged when ctrl_valid is high but ctrl_ready is low.

Reset
REQ-029 SHALL apply reset when rst is low at a rising edge of clk: occupancy EMPTY, outs_valid 0, outs 0, outs_last 0, idx 0, accumulator BASE_VALUE, ctrl_ready 0.
REQ-030 SHALL raise ctrl_ready on the first edge after rst returns high.
REQ-031 SHALL discard all buffered tokens and restart the sequence at BASE_VALUE when reset is asserted mid-operation.

Structure
REQ-032 SHALL place the occupancy enum (EMPTY, ONE, FULL) and a clog2-based width function in the shared package handshake_pkg.
REQ-033 SHALL implement the 2-entry buffer as sub-module handshake_elastic_buffer_2, parameterised by payload width (DATA_WIDTH+1, carrying outs_last).
REQ-034 SHALL keep the top level limited to the index counter, the accumulator and the buffer instance.

Verification
(All scenarios use DATA_WIDTH=12, BASE_VALUE=12'hF0B, STRIDE=1, SEQ_LEN=4 unless stated.)
REQ-035 SHALL cover streaming: outs_ready=1, ctrl_valid=1 for 6 cycles -> outs F0B, F0C, F0D, F0E, F0B, F0C on consecutive cycles; outs_last high on the F0E token only.
REQ-036 SHALL cover backpressure: outs_ready=0, ctrl_valid=1 -> 2 tokens accepted; ctrl_ready low from the cycle after the second acceptance; outs holds F0B; then outs_ready=1 -> F0B, F0C drained in order.
REQ-037 SHALL cover simultaneous push and pop in the ONE state: occupancy remains ONE, ctrl_ready stays 1, and no value is skipped.
REQ-038 SHALL cover arithmetic wrap with STRIDE=12'h0F8 and SEQ_LEN=3 -> F0B, 003, 0FB, then F0B.
REQ-039 SHALL cover reset mid-stream: rst low for 1 cycle with FULL occupancy -> outs_valid 0 and ctrl_ready 0 during reset; the next token after release is F0B.
REQ-040 SHALL cover SEQ_LEN=1: every token equals BASE_VALUE and outs_last is always 1.
